// File: rtl/line_fetch_pkg.sv
// Shared types and sizing helpers for the line fetch sequencer.
// Row index widths never collapse to zero bits, even for single-row memories.
package line_fetch_pkg;

  localparam int DEF_IMG_ROWS = 32;
  localparam int DEF_TPL_ROWS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } fsm_state_e;

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int img_row_w(input int img_rows);
    return row_w(img_rows);
  endfunction

  function automatic int tpl_row_w(input int tpl_rows);
    return row_w(tpl_rows);
  endfunction

endpackage

// File: rtl/line_fetch_ctrl_if.sv
// Handshake bundle between the line fetch sequencer and the line memories / matcher.
// The abort input exists only when LINE_FETCH_CTRL_ABORT_EN is defined.
interface line_fetch_ctrl_if #(
  parameter int IMG_ROWS = line_fetch_pkg::DEF_IMG_ROWS,
  parameter int TPL_ROWS = line_fetch_pkg::DEF_TPL_ROWS
);
  localparam int IMG_ROW_W = line_fetch_pkg::img_row_w(IMG_ROWS);
  localparam int TPL_ROW_W = line_fetch_pkg::tpl_row_w(TPL_ROWS);

  logic                 start;
  logic                 stall;
`ifdef LINE_FETCH_CTRL_ABORT_EN
  logic                 abort;
`endif
  logic                 rd_req;
  logic                 rd_ack;
  logic [IMG_ROW_W-1:0] img_row;
  logic [TPL_ROW_W-1:0] tpl_row;
  logic                 win_valid;
  logic                 win_first;
  logic                 win_last;
  logic                 busy;
  logic                 done;

  modport master (
`ifdef LINE_FETCH_CTRL_ABORT_EN
    input  abort,
`endif
    input  start, stall, rd_ack,
    output rd_req, img_row, tpl_row, win_valid, win_first, win_last, busy, done
  );

  modport slave (
`ifdef LINE_FETCH_CTRL_ABORT_EN
    output abort,
`endif
    output start, stall, rd_ack,
    input  rd_req, img_row, tpl_row, win_valid, win_first, win_last, busy, done
  );

endinterface

// File: rtl/win_row_counter.sv
// Nested window-position / template-row counter; template rows run from the top row
// down to 0 while the stored index counts up from 0, so reset leaves every counter at 0.
module win_row_counter #(
  parameter int IMG_ROWS = line_fetch_pkg::DEF_IMG_ROWS,
  parameter int TPL_ROWS = line_fetch_pkg::DEF_TPL_ROWS,
  localparam int IMG_ROW_W = line_fetch_pkg::img_row_w(IMG_ROWS),
  localparam int TPL_ROW_W = line_fetch_pkg::tpl_row_w(TPL_ROWS)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 clr,
  input  logic                 adv,
  output logic [TPL_ROW_W-1:0] tpl_row,
  output logic [IMG_ROW_W-1:0] win_pos,
  output logic                 last
);
  localparam logic [TPL_ROW_W-1:0] TPL_MAX = TPL_ROW_W'(TPL_ROWS - 1);
  localparam logic [IMG_ROW_W-1:0] POS_MAX = IMG_ROW_W'(IMG_ROWS - TPL_ROWS);

  logic [TPL_ROW_W-1:0] tpl_idx_reg;
  logic [IMG_ROW_W-1:0] win_pos_reg;
  logic                 tpl_wrap;

  assign tpl_wrap = (tpl_idx_reg == TPL_MAX);
  assign last     = tpl_wrap && (win_pos_reg == POS_MAX);
  assign tpl_row  = TPL_MAX - tpl_idx_reg;
  assign win_pos  = win_pos_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tpl_idx_reg <= '0;
      win_pos_reg <= '0;
    end else if (clr) begin
      tpl_idx_reg <= '0;
      win_pos_reg <= '0;
    end else if (adv) begin
      if (tpl_wrap) begin
        tpl_idx_reg <= '0;
        win_pos_reg <= last ? '0 : win_pos_reg + 1'b1;
      end else begin
        tpl_idx_reg <= tpl_idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_fetch_ctrl.sv
// Paired image/template line-read sequencer feeding the template matcher's input buffer.
// Optional LINE_FETCH_CTRL_ABORT_EN adds an abort pulse that returns to IDLE without done.
module line_fetch_ctrl
  import line_fetch_pkg::*;
#(
  parameter int IMG_ROWS = DEF_IMG_ROWS,
  parameter int TPL_ROWS = DEF_TPL_ROWS
) (
  input logic               CLK,
  input logic               RST_N,
  line_fetch_ctrl_if.master bus
);
  localparam int IMG_ROW_W = img_row_w(IMG_ROWS);
  localparam int TPL_ROW_W = tpl_row_w(TPL_ROWS);
  localparam logic [TPL_ROW_W-1:0] TPL_MAX = TPL_ROW_W'(TPL_ROWS - 1);

  fsm_state_e           state_reg, state_next;
  logic [TPL_ROW_W-1:0] tpl_row;
  logic [IMG_ROW_W-1:0] win_pos;
  logic                 cnt_last;
  logic                 abort;
  logic                 ack_accept;
  logic                 rd_req, busy, done;
  logic                 win_valid_reg, win_first_reg, win_last_reg;

`ifdef LINE_FETCH_CTRL_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif

  // An ack only counts while a request is actually presented and no abort is pending.
  assign ack_accept = (state_reg == ISSUE) && bus.rd_ack && !abort;

  win_row_counter #(
    .IMG_ROWS(IMG_ROWS),
    .TPL_ROWS(TPL_ROWS)
  ) u_counter (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clr    (abort),
    .adv    (ack_accept),
    .tpl_row(tpl_row),
    .win_pos(win_pos),
    .last   (cnt_last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_req     = (state_reg == ISSUE);
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.start) state_next = bus.stall ? HOLD : ISSUE;
        HOLD:    if (!bus.stall) state_next = ISSUE;
        ISSUE: begin
          // Stall only takes effect once the outstanding request has been acked.
          if (bus.rd_ack) begin
            if (cnt_last) begin
              state_next = DONE;
            end else if (bus.stall) begin
              state_next = HOLD;
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Flags describe the pair the input buffer captures on the ack edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      win_valid_reg <= 1'b0;
      win_first_reg <= 1'b0;
      win_last_reg  <= 1'b0;
    end else begin
      win_valid_reg <= ack_accept;
      win_first_reg <= ack_accept && (tpl_row == TPL_MAX);
      win_last_reg  <= ack_accept && (tpl_row == '0);
    end
  end

  assign bus.rd_req    = rd_req;
  assign bus.img_row   = rd_req ? (win_pos + IMG_ROW_W'(tpl_row)) : '0;
  assign bus.tpl_row   = rd_req ? tpl_row : '0;
  assign bus.win_valid = win_valid_reg;
  assign bus.win_first = win_first_reg;
  assign bus.win_last  = win_last_reg;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule
